// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the data memory between CPU single
// accesses and DMA bursts; read data is registered per requester.
module data_mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RAM_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [2:0]        dma_len,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DMA  = 2'd2
  } state_t;

  localparam logic [RAM_AW-1:0] OFF_ONE = 'd1;

  state_t              r_state;
  state_t              w_next;
  logic                r_last_dma;
  logic                r_we;
  logic [ADDR_W-1:0]   r_base;
  logic [2:0]          r_cnt;
  logic [RAM_AW-1:0]   r_off;

  logic                w_pick_cpu;
  logic                w_pick_dma;
  logic                w_last_beat;
  logic [RAM_AW-1:0]   w_low;
  logic [ADDR_W-1:0]   w_dma_addr;

  // On a tie the requester that did not own the memory last wins.
  assign w_pick_cpu  = cpu_req & (~dma_req | r_last_dma);
  assign w_pick_dma  = dma_req & ~w_pick_cpu;
  assign w_last_beat = (r_cnt == 3'd0);
  assign w_low       = r_base[RAM_AW-1:0] + r_off;
  assign w_dma_addr  = {r_base[ADDR_W-1:RAM_AW], w_low};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick_cpu)      w_next = S_CPU;
        else if (w_pick_dma) w_next = S_DMA;
      end
      S_CPU:   w_next = S_IDLE;
      S_DMA:   if (w_last_beat) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_gnt         = 1'b0;
    dma_gnt         = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    case (r_state)
      S_CPU: begin
        cpu_gnt         = 1'b1;
        mem_access_addr = cpu_addr;
        mem_write_data  = cpu_wdata;
        mem_write_en    = cpu_we;
        mem_read        = ~cpu_we;
      end
      S_DMA: begin
        dma_gnt         = 1'b1;
        mem_access_addr = w_dma_addr;
        mem_write_data  = dma_wdata;
        mem_write_en    = r_we;
        mem_read        = ~r_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_dma <= 1'b1;
      r_we       <= 1'b0;
      r_base     <= '0;
      r_cnt      <= '0;
      r_off      <= '0;
    end else begin
      if (r_state == S_IDLE && w_pick_dma) begin
        r_base <= dma_addr;
        r_we   <= dma_we;
        r_cnt  <= dma_len;
        r_off  <= '0;
      end
      if (r_state == S_DMA) begin
        r_off <= r_off + OFF_ONE;
        r_cnt <= r_cnt - 3'd1;
        if (w_last_beat) r_last_dma <= 1'b1;
      end
      if (r_state == S_CPU) r_last_dma <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
      dma_done   <= 1'b0;
    end else begin
      cpu_rvalid <= (r_state == S_CPU) & ~cpu_we;
      dma_rvalid <= (r_state == S_DMA) & ~r_we;
      dma_done   <= (r_state == S_DMA) & w_last_beat;
      if (r_state == S_CPU && !cpu_we) cpu_rdata <= mem_read_data;
      if (r_state == S_DMA && !r_we)   dma_rdata <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: 8-word memory model plus a scenario
// reference model (expected memory image, owner flag, cycle timing).
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr;
  logic [2:0]  dma_len;
  logic [15:0] dma_wdata;
  logic        dma_gnt, dma_rvalid, dma_done;
  logic [15:0] dma_rdata;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read;

  data_mem_arbiter #(.DATA_W(16), .ADDR_W(16), .RAM_AW(3)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_len(dma_len), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .dma_done(dma_done),
    .mem_access_addr(mem_access_addr),
    .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [8];
  always @(posedge clk)
    if (mem_write_en) ram[mem_access_addr[2:0]] <= mem_write_data;
  assign mem_read_data = mem_read ? ram[mem_access_addr[2:0]] : 16'h0;

  int n_err = 0;
  int n_chk = 0;
  logic [15:0] ref_mem [8];
  logic        ref_last_dma;

  logic [15:0] b_wd [8];
  logic [15:0] b_addrs [8];
  logic [15:0] b_rds [8];
  int b_beats, b_nrv, b_first, b_last, b_done_c, b_nrv_done;

  always @(negedge clk) begin
    if (!rst) begin
      n_chk++;
      if ((cpu_gnt && dma_gnt) || (mem_write_en && mem_read)) begin
        n_err++;
        $display("FAIL excl got gnt=%b%b we/rd=%b%b exp no overlap",
                 cpu_gnt, dma_gnt, mem_write_en, mem_read);
      end
    end
  end

  task automatic cpu_do(input logic we, input logic [15:0] a,
                        input logic [15:0] d, output int lat,
                        output logic wen_g, output int wen_n,
                        output logic rv, output logic [15:0] rd);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = 40; wen_n = 0; wen_g = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_write_en) wen_n++;
      if (cpu_gnt) begin
        lat = c + 1;
        wen_g = mem_write_en;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    if (mem_write_en) wen_n++;
    rv = cpu_rvalid;
    rd = cpu_rdata;
  endtask

  task automatic dma_burst(input logic we, input logic [15:0] a,
                           input logic [2:0] len);
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_len = len;
    dma_wdata = b_wd[0];
    b_beats = 0; b_nrv = 0; b_first = -1; b_last = -1;
    b_done_c = -1; b_nrv_done = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dma_rvalid && b_nrv < 8) begin
        b_rds[b_nrv] = dma_rdata;
        b_nrv++;
      end
      if (dma_done) begin
        b_done_c = c;
        b_nrv_done = b_nrv;
        break;
      end
      if (dma_gnt) begin
        if (b_first < 0) b_first = c;
        b_last = c;
        if (b_beats < 8) b_addrs[b_beats] = mem_access_addr;
        dma_wdata = b_wd[b_beats % 8];
        b_beats++;
      end
      @(posedge clk); #1;
      if (b_beats > 0) dma_req = 1'b0;
    end
    dma_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ref_last_dma = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, dma_done,
         mem_write_en, mem_read} !== 7'd0 ||
        cpu_rdata !== 16'h0 || dma_rdata !== 16'h0 ||
        mem_access_addr !== 16'h0 || mem_write_data !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs got nonzero output exp all 0");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ref_last_dma = 1'b1;
  endtask

  task automatic test_cpu_rw();
    int lat, wn;
    logic wg, rv;
    logic [15:0] rd;
    cpu_do(1'b1, 16'h0003, 16'hBEEF, lat, wg, wn, rv, rd);
    ref_mem[3] = 16'hBEEF;
    ref_last_dma = 1'b0;
    n_chk++;
    if (lat !== 2 || wg !== 1'b1 || wn !== 1 || rv !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_write got lat=%0d wen=%b/%0d rv=%b exp 2 1/1 0",
               lat, wg, wn, rv);
    end
    cpu_do(1'b0, 16'h0003, 16'h0, lat, wg, wn, rv, rd);
    n_chk++;
    if (lat !== 2 || wg !== 1'b0 || wn !== 0 || rv !== 1'b1 ||
        rd !== 16'hBEEF) begin
      n_err++;
      $display("FAIL cpu_read got lat=%0d wen=%0d rv=%b rd=%h exp 2 0 1 beef",
               lat, wn, rv, rd);
    end
    @(negedge clk);
    n_chk++;
    if (cpu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_rvalid_pulse got %b exp 0", cpu_rvalid);
    end
  endtask

  task automatic test_preload();
    int lat, wn;
    logic wg, rv;
    logic [15:0] rd, a, d;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      a[2:0] = i[2:0];
      d = 16'($urandom);
      cpu_do(1'b1, a, d, lat, wg, wn, rv, rd);
      ref_mem[i] = d;
      n_chk++;
      if (lat !== 2 || wg !== 1'b1) begin
        n_err++;
        $display("FAIL preload[%0d] got lat=%0d wen=%b exp 2 1", i, lat, wg);
      end
    end
    ref_last_dma = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [5];
    int gc [5];
    int k, nrv;
    for (int i = 0; i < 5; i++) addrs[i] = 16'($urandom);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addrs[0];
    k = 0; nrv = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (cpu_rvalid && nrv < 5) begin
        n_chk++;
        if (cpu_rdata !== ref_mem[addrs[nrv][2:0]]) begin
          n_err++;
          $display("FAIL b2b_data[%0d] got %h exp %h", nrv, cpu_rdata,
                   ref_mem[addrs[nrv][2:0]]);
        end
        nrv++;
      end
      if (cpu_gnt && k < 5) begin
        gc[k] = c;
        k++;
      end
      if (k == 5 && nrv == 5) break;
      @(posedge clk); #1;
      if (k == 5) cpu_req = 1'b0;
      else        cpu_addr = addrs[k];
    end
    cpu_req = 1'b0;
    ref_last_dma = 1'b0;
    n_chk++;
    if (k !== 5 || nrv !== 5 || gc[0] !== 1) begin
      n_err++;
      $display("FAIL b2b_count got gnt=%0d rv=%0d first=%0d exp 5 5 1",
               k, nrv, gc[0]);
    end else begin
      for (int i = 1; i < 5; i++) begin
        n_chk++;
        if (gc[i] - gc[i-1] !== 2) begin
          n_err++;
          $display("FAIL b2b_spacing[%0d] got %0d exp 2", i,
                   gc[i] - gc[i-1]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int lat, wn, cg, dg, dd, nb, ecg, edg, edd;
    logic wg, rv, lone, cpu_first;
    logic [15:0] rd, ca, cd, da, la, ld;
    logic [2:0] dl, ix;
    logic [15:0] wd [8];
    do_reset();
    for (int r = 0; r < 6; r++) begin
      lone = (r == 1) || (r > 1 && $urandom_range(0, 1) == 1);
      if (lone) begin
        la = 16'($urandom);
        ld = 16'($urandom);
        cpu_do(1'b1, la, ld, lat, wg, wn, rv, rd);
        ref_mem[la[2:0]] = ld;
        ref_last_dma = 1'b0;
      end
      ca = 16'($urandom);
      cd = 16'($urandom);
      da = (r == 0) ? 16'h0000 : 16'($urandom);
      dl = (r == 0) ? 3'd0 : 3'($urandom_range(0, 2));
      for (int i = 0; i < 8; i++) wd[i] = 16'($urandom);
      cpu_first = ref_last_dma;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = ca; cpu_wdata = cd;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = da; dma_len = dl;
      dma_wdata = wd[0];
      cg = -1; dg = -1; dd = -1; nb = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (cpu_gnt && cg < 0) cg = c;
        if (dma_done && dd < 0) dd = c;
        if (dma_gnt) begin
          if (dg < 0) dg = c;
          dma_wdata = wd[nb % 8];
          nb++;
        end
        if (cg >= 0 && dd >= 0) break;
        @(posedge clk); #1;
        if (cg >= 0) cpu_req = 1'b0;
        if (dg >= 0) dma_req = 1'b0;
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
      dma_req = 1'b0;
      if (cpu_first) begin
        ecg = 1; edg = 3; edd = 4 + int'(dl);
      end else begin
        edg = 1; edd = 2 + int'(dl); ecg = 3 + int'(dl);
      end
      n_chk++;
      if ((cg >= 0 && dg >= 0 && (cg < dg)) !== cpu_first) begin
        n_err++;
        $display("FAIL rr_winner[%0d] got cpu@%0d dma@%0d exp cpu_first=%b",
                 r, cg, dg, cpu_first);
      end
      n_chk++;
      if (cg !== ecg || dg !== edg || dd !== edd || nb !== int'(dl) + 1) begin
        n_err++;
        $display("FAIL rr_timing[%0d] got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
                 r, cg, dg, dd, nb, ecg, edg, edd, int'(dl) + 1);
      end
      if (cpu_first) ref_mem[ca[2:0]] = cd;
      for (int k = 0; k <= int'(dl); k++) begin
        ix = da[2:0] + k[2:0];
        ref_mem[ix] = wd[k];
      end
      if (!cpu_first) ref_mem[ca[2:0]] = cd;
      ref_last_dma = cpu_first;
    end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (ram[i] !== ref_mem[i]) begin
        n_err++;
        $display("FAIL rr_mem[%0d] got %h exp %h", i, ram[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_dma_wrap();
    logic [15:0] a, ea;
    logic [2:0] len, ix;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        a = 16'h0006; len = 3'd3;
        b_wd[0] = 16'h11; b_wd[1] = 16'h22;
        b_wd[2] = 16'h33; b_wd[3] = 16'h44;
      end else begin
        a = 16'($urandom); len = 3'($urandom_range(0, 7));
        for (int i = 0; i < 8; i++) b_wd[i] = 16'($urandom);
      end
      dma_burst(1'b1, a, len);
      n_chk++;
      if (b_first !== 1 || b_beats !== int'(len) + 1 ||
          b_last !== 1 + int'(len) || b_done_c !== 2 + int'(len) ||
          b_nrv !== 0) begin
        n_err++;
        $display("FAIL wr_timing[%0d] got %0d/%0d/%0d/%0d exp 1/%0d/%0d/%0d",
                 t, b_first, b_beats, b_last, b_done_c,
                 int'(len) + 1, 1 + int'(len), 2 + int'(len));
      end
      for (int i = 0; i <= int'(len) && i < b_beats; i++) begin
        ea = (a & 16'hFFF8) | ((a + 16'(i)) & 16'h0007);
        n_chk++;
        if (b_addrs[i] !== ea) begin
          n_err++;
          $display("FAIL wr_addr[%0d.%0d] got %h exp %h", t, i,
                   b_addrs[i], ea);
        end
        ix = a[2:0] + i[2:0];
        ref_mem[ix] = b_wd[i];
      end
      ref_last_dma = 1'b1;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (ram[i] !== ref_mem[i]) begin
        n_err++;
        $display("FAIL wr_mem[%0d] got %h exp %h", i, ram[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_dma_read_preempt();
    int lat, wn, ng;
    logic wg, rv;
    logic [15:0] rd;
    test_preload();
    ng = 0;
    fork
      dma_burst(1'b0, 16'h0000, 3'd7);
      begin
        for (int c = 0; c < 40 && ng < 2; c++) begin
          @(negedge clk);
          if (dma_gnt) ng++;
        end
        cpu_do(1'b0, 16'h0005, 16'h0, lat, wg, wn, rv, rd);
      end
    join
    ref_last_dma = 1'b0;
    n_chk++;
    if (b_beats !== 8 || b_nrv !== 8 || b_nrv_done !== 8 ||
        b_first !== 1 || b_done_c !== 9) begin
      n_err++;
      $display("FAIL rd_burst got beats=%0d rv=%0d rv@done=%0d first=%0d done=%0d exp 8 8 8 1 9",
               b_beats, b_nrv, b_nrv_done, b_first, b_done_c);
    end
    for (int i = 0; i < 8 && i < b_nrv; i++) begin
      n_chk++;
      if (b_rds[i] !== ref_mem[i]) begin
        n_err++;
        $display("FAIL rd_data[%0d] got %h exp %h", i, b_rds[i], ref_mem[i]);
      end
    end
    n_chk++;
    if (lat !== 8 || rv !== 1'b1 || rd !== ref_mem[5]) begin
      n_err++;
      $display("FAIL rd_cpu_wait got lat=%0d rv=%b rd=%h exp 8 1 %h",
               lat, rv, rd, ref_mem[5]);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [15:0] w [5];
    int gc, dn;
    for (int i = 0; i < 5; i++) w[i] = ~ref_mem[i];
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0000;
    dma_len = 3'd4; dma_wdata = w[0];
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (dma_gnt !== 1'b1 || mem_access_addr !== 16'h0 ||
        mem_write_en !== 1'b1) begin
      n_err++;
      $display("FAIL rmb_beat1 got gnt=%b addr=%h we=%b exp 1 0000 1",
               dma_gnt, mem_access_addr, mem_write_en);
    end
    @(posedge clk); #1;
    dma_req = 1'b0;
    dma_wdata = w[1];
    @(negedge clk);
    n_chk++;
    if (dma_gnt !== 1'b1 || mem_access_addr !== 16'h1 ||
        mem_write_en !== 1'b1) begin
      n_err++;
      $display("FAIL rmb_beat2 got gnt=%b addr=%h we=%b exp 1 0001 1",
               dma_gnt, mem_access_addr, mem_write_en);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, dma_done,
         mem_write_en, mem_read} !== 7'd0 ||
        mem_access_addr !== 16'h0 || mem_write_data !== 16'h0 ||
        cpu_rdata !== 16'h0 || dma_rdata !== 16'h0) begin
      n_err++;
      $display("FAIL rmb_async got we=%b gnt=%b exp all outputs 0",
               mem_write_en, dma_gnt);
    end
    ref_mem[0] = w[0];
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (cpu_gnt || dma_gnt || dma_done || mem_write_en) begin
        n_err++;
        $display("FAIL rmb_hold got gnt=%b%b done=%b we=%b exp 0",
                 cpu_gnt, dma_gnt, dma_done, mem_write_en);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ref_last_dma = 1'b1;
    gc = -1; dn = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dma_done) dn++;
      if (cpu_gnt) begin
        gc = c;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    if (dma_done) dn++;
    ref_last_dma = 1'b0;
    n_chk++;
    if (gc !== 1 || dn !== 0 || cpu_rvalid !== 1'b1 ||
        cpu_rdata !== ref_mem[1]) begin
      n_err++;
      $display("FAIL rmb_after got gnt@%0d done=%0d rv=%b rd=%h exp 1 0 1 %h",
               gc, dn, cpu_rvalid, cpu_rdata, ref_mem[1]);
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (ram[i] !== ref_mem[i]) begin
        n_err++;
        $display("FAIL rmb_mem[%0d] got %h exp %h", i, ram[i], ref_mem[i]);
      end
    end
  endtask

  task automatic test_idle();
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_chk++;
      if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, dma_done,
           mem_write_en, mem_read} !== 7'd0 ||
          mem_access_addr !== 16'h0 || mem_write_data !== 16'h0) begin
        n_err++;
        $display("FAIL idle[%0d] got ctl=%b addr=%h wd=%h exp 0", c,
                 {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, dma_done,
                  mem_write_en, mem_read}, mem_access_addr, mem_write_data);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0;
    dma_wdata = '0;
    ref_last_dma = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = '0;
      b_wd[i] = '0;
    end
    test_reset();
    test_cpu_rw();
    test_preload();
    test_back_to_back();
    test_round_robin();
    test_dma_wrap();
    test_dma_read_preempt();
    test_reset_mid_burst();
    test_idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory (16-bit words, 8 locations decoded from address bits [2:0], synchronous write, combinational read gated by `mem_read`) between two requesters.
- Requester 0 is the CPU load/store stage, which issues single accesses.
- Requester 1 is a DMA/loader port, which issues bursts of 1-8 beats with auto-incrementing address.
- The block arbitrates round-robin, drives the memory control/address/data lines, and returns registered read data with a valid strobe to the owning requester.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, address width on both requester ports and the memory port.
- RAM_AW, 3, number of decoded address bits; DMA burst address wraps within this field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held with cpu_we/cpu_addr/cpu_wdata stable until cpu_gnt.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  high during the cycle the CPU access is on the memory port.
- cpu_rvalid  out  1  one-cycle pulse, cycle after a CPU read grant.
- cpu_rdata  out  DATA_W  registered CPU read data.
- dma_req  in  1  burst request; held with dma_we/dma_addr/dma_len until first dma_gnt.
- dma_we  in  1  burst direction.
- dma_addr  in  ADDR_W  burst start address.
- dma_len  in  3  burst length minus 1 (0 gives 1 beat, 7 gives 8 beats).
- dma_wdata  in  DATA_W  write data for the current beat; sampled while dma_gnt=1.
- dma_gnt  out  1  high for each beat on the memory port.
- dma_rvalid  out  1  pulse, cycle after each DMA read beat.
- dma_rdata  out  DATA_W  registered DMA read data.
- dma_done  out  1  one-cycle pulse, cycle after the last beat.
- mem_access_addr  out  ADDR_W  memory address.
- mem_write_data  out  DATA_W  memory write data.
- mem_write_en  out  1  memory write enable.
- mem_read  out  1  memory read enable.
- mem_read_data  in  DATA_W  combinational memory read data.

Behaviour:
- States: IDLE, CPU_ACC, DMA_BURST.
- A `last_owner` flag drives the round-robin.
- Latched burst registers: base address, direction, remaining-beat counter (3 bits), beat offset (3 bits).
- Reset (async):
  - State returns to IDLE; last_owner=DMA, so the CPU wins the first tie.
  - All outputs are 0: gnt, rvalid, done, mem_* and rdata.
- IDLE:
  - mem_* are driven 0.
  - At the clock edge: cpu_req only gives CPU_ACC. dma_req only gives DMA_BURST (latches dma_addr, dma_we, dma_len; offset=0).
  - Both requests pending: go to the requester that is not last_owner.
  - Neither pending: stay in IDLE.
- CPU_ACC (exactly 1 cycle):
  - cpu_gnt=1; mem_access_addr=cpu_addr; mem_write_en=cpu_we; mem_read=~cpu_we; mem_write_data=cpu_wdata.
  - On a read, mem_read_data is captured into cpu_rdata at the closing edge; cpu_rvalid=1 for the next cycle.
  - Next state is IDLE; last_owner=CPU.
  - Latency from cpu_req rising to cpu_rvalid is 2 cycles when uncontended. Back-to-back CPU accesses take 2 cycles each.
  - The requester deasserts or changes its request in the cycle after gnt.
- DMA_BURST (dma_len+1 consecutive cycles, one beat per cycle):
  - dma_gnt=1 throughout.
  - mem_access_addr = {base[ADDR_W-1:RAM_AW], base[RAM_AW-1:0]+offset}: the low field wraps mod 8 and the upper bits are unchanged.
  - mem_write_en=we; mem_read=~we; mem_write_data=dma_wdata.
  - Read beats capture into dma_rdata; dma_rvalid pulses in the following cycle.
  - Each edge increments offset and decrements the counter.
  - At the last beat's edge: go to IDLE, last_owner=DMA, dma_done=1 for the next cycle (coincident with the final dma_rvalid on reads).
  - No preemption: a CPU request arriving mid-burst waits, worst case 9 cycles to grant.
- Gating:
  - cpu_gnt and dma_gnt are never both 1.
  - mem_write_en and mem_read are never both 1.
  - mem_write_en and mem_read are combinational from the state register, so assertion of rst drops them immediately.
- Reset mid-burst: the burst is abandoned, no dma_done, no further writes. The requester must re-issue.
- A request arriving during the reset cycle is not granted until reset deasserts.

Test Plan:
- Reset, then CPU write addr 0x0003 data 0xBEEF, then CPU read 0x0003 -> cpu_gnt 1 cycle each; cpu_rvalid 2 cycles after the read request with cpu_rdata=0xBEEF; mem_write_en only in the write grant cycle.
- cpu_req and dma_req (write, addr 0x0000, len 0) asserted in the same cycle right after reset -> CPU granted first. Repeat the simultaneous request after both complete -> the winner alternates.
- DMA write burst addr 0x0006, len 3, data 0x11,0x22,0x33,0x44 -> mem_access_addr 6,7,0,1 (wrap); dma_gnt 4 cycles; dma_done pulses the cycle after the 4th beat.
- DMA read burst addr 0x0000, len 7 after preloading 8 words -> 8 dma_rvalid pulses in order, data matching; dma_done coincident with the 8th rvalid. A cpu_req raised at beat 2 is granted only after the burst ends.
- Assert rst during beat 2 of a 5-beat DMA write -> mem_write_en drops immediately; words 3-5 are unchanged; dma_done is never asserted; all outputs are 0.
- Idle checks with no requests for 20 cycles -> all mem_* outputs 0, no gnt/rvalid; throughout all tests cpu_gnt and dma_gnt are never high together.
